// File: rtl/keypad_entry_pkg.sv
// Shared types and time-limit constants for the keypad entry block.
// Holds the FSM encoding and the legal-time check.
package keypad_entry_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_STORE,
    S_WAIT_RELEASE
  } state_e;

  localparam logic [3:0] KEY_NONE       = 4'd10;
  localparam logic [3:0] MAX_MS_HR      = 4'd2;
  localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN     = 4'd5;

  function automatic logic legal_time(
    input logic [3:0] ms_hr,
    input logic [3:0] ls_hr,
    input logic [3:0] ms_min
  );
    logic hr_ok;
    hr_ok = (ms_hr < MAX_MS_HR) ||
            ((ms_hr == MAX_MS_HR) &&
             (ls_hr <= MAX_LS_HR_AT_2));
    return hr_ok && (ms_min <= MAX_MS_MIN);
  endfunction

endpackage

// File: rtl/keypad_entry_debounce.sv
// Debounce cycle counter shared by the press and release phases.
// done_o flags the last cycle of a CYCLES-long stable window.
module key_debounce #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic done_o
);

  localparam int unsigned W =
    (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_entry.sv
// Keypad time entry: debounced digit capture, shift buffer,
// inactivity timeout and alarm/time commit with legality check.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_SECS    = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_pressed,
  input  logic [3:0] key_code,
  input  logic       one_second,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic [3:0] key_ms_hr,
  output logic [3:0] key_ls_hr,
  output logic [3:0] key_ms_min,
  output logic [3:0] key_ls_min,
  output logic       show_new_time,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       entry_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_SECS + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_SECS - 1);

  state_e state_q, state_d;

  logic       kp_s1_q, kp_s2_q;
  logic [3:0] kc_s1_q, kc_s2_q;
  logic [3:0] samp_q, samp_d;
  logic [3:0] mh_q, lh_q, mm_q, lm_q;
  logic [3:0] mh_d, lh_d, mm_d, lm_d;
  logic       show_q, show_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       a_prev_q, t_prev_q;
  logic       lda_q, lda_d, ldc_q, ldc_d, err_q, err_d;

  logic dbc_clr, dbc_inc, dbc_done, store;
  logic rise_a, rise_t, commit;

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_dbc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (dbc_clr),
    .inc_i   (dbc_inc),
    .done_o  (dbc_done)
  );

  always_comb begin
    state_d = state_q;
    dbc_clr = 1'b0;
    dbc_inc = 1'b0;
    store   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (kp_s2_q) begin
          state_d = S_DEBOUNCE;
          dbc_clr = 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (kp_s2_q && (kc_s2_q == samp_q)) begin
          if (dbc_done) state_d = S_STORE;
          else          dbc_inc = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STORE: begin
        store   = 1'b1;
        dbc_clr = 1'b1;
        state_d = S_WAIT_RELEASE;
      end
      S_WAIT_RELEASE: begin
        if (kp_s2_q)       dbc_clr = 1'b1;
        else if (dbc_done) state_d = S_IDLE;
        else               dbc_inc = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rise_a = alarm_button & ~a_prev_q;
  assign rise_t = time_button & ~t_prev_q;
  assign commit = show_q & (rise_a ^ rise_t);

  // Priority: commit over store over timeout.
  always_comb begin
    samp_d = samp_q;
    mh_d   = mh_q;
    lh_d   = lh_q;
    mm_d   = mm_q;
    lm_d   = lm_q;
    show_d = show_q;
    tmo_d  = tmo_q;
    lda_d  = 1'b0;
    ldc_d  = 1'b0;
    err_d  = 1'b0;
    if (state_q == S_IDLE && kp_s2_q) samp_d = kc_s2_q;
    if (commit) begin
      show_d = 1'b0;
      tmo_d  = '0;
      if (legal_time(mh_q, lh_q, mm_q)) begin
        lda_d = rise_a;
        ldc_d = rise_t;
      end else begin
        err_d = 1'b1;
        mh_d  = '0;
        lh_d  = '0;
        mm_d  = '0;
        lm_d  = '0;
      end
    end else if (store && (samp_q < KEY_NONE)) begin
      // A fresh entry always starts from 0000.
      mh_d   = show_q ? lh_q : 4'd0;
      lh_d   = show_q ? mm_q : 4'd0;
      mm_d   = show_q ? lm_q : 4'd0;
      lm_d   = samp_q;
      show_d = 1'b1;
      tmo_d  = '0;
    end else if (show_q && one_second) begin
      if (tmo_q >= TLAST) begin
        mh_d   = '0;
        lh_d   = '0;
        mm_d   = '0;
        lm_d   = '0;
        show_d = 1'b0;
        tmo_d  = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      kp_s1_q  <= 1'b0;
      kp_s2_q  <= 1'b0;
      kc_s1_q  <= '0;
      kc_s2_q  <= '0;
      samp_q   <= '0;
      mh_q     <= '0;
      lh_q     <= '0;
      mm_q     <= '0;
      lm_q     <= '0;
      show_q   <= 1'b0;
      tmo_q    <= '0;
      a_prev_q <= 1'b0;
      t_prev_q <= 1'b0;
      lda_q    <= 1'b0;
      ldc_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kp_s1_q  <= key_pressed;
      kp_s2_q  <= kp_s1_q;
      kc_s1_q  <= key_code;
      kc_s2_q  <= kc_s1_q;
      samp_q   <= samp_d;
      mh_q     <= mh_d;
      lh_q     <= lh_d;
      mm_q     <= mm_d;
      lm_q     <= lm_d;
      show_q   <= show_d;
      tmo_q    <= tmo_d;
      a_prev_q <= alarm_button;
      t_prev_q <= time_button;
      lda_q    <= lda_d;
      ldc_q    <= ldc_d;
      err_q    <= err_d;
    end
  end

  assign key_ms_hr     = mh_q;
  assign key_ls_hr     = lh_q;
  assign key_ms_min    = mm_q;
  assign key_ls_min    = lm_q;
  assign show_new_time = show_q;
  assign load_new_a    = lda_q;
  assign load_new_c    = ldc_q;
  assign entry_error   = err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: vector table for digit entry
// plus hand sequences for commit, timeout, glitch and reset cases.
module tb_keypad_entry;
  import keypad_entry_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_pressed = 1'b0;
  logic [3:0] key_code = '0;
  logic       one_second = 1'b0;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic       show_new_time, load_new_a, load_new_c, entry_error;

  int checks = 0;
  int errors = 0;
  int na = 0, nc = 0, ne = 0;
  int na0, nc0, ne0;

  keypad_entry #(.DEBOUNCE_CYCLES(4), .TIMEOUT_SECS(10)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .key_pressed   (key_pressed),
    .key_code      (key_code),
    .one_second    (one_second),
    .alarm_button  (alarm_button),
    .time_button   (time_button),
    .key_ms_hr     (key_ms_hr),
    .key_ls_hr     (key_ls_hr),
    .key_ms_min    (key_ms_min),
    .key_ls_min    (key_ls_min),
    .show_new_time (show_new_time),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .entry_error   (entry_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_new_a)  na++;
    if (load_new_c)  nc++;
    if (entry_error) ne++;
  end

  typedef struct {
    logic [3:0]  code;
    logic [15:0] exp_dig;
    logic        exp_show;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [15:0] digits();
    return {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    key_code = code;
    key_pressed = 1'b1;
    repeat (6) @(negedge clk);
    key_pressed = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic buttons(input logic a, input logic t);
    na0 = na; nc0 = nc; ne0 = ne;
    alarm_button = a;
    time_button = t;
    @(negedge clk);
    alarm_button = 1'b0;
    time_button = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic strobes(input string name, input int ea,
                         input int ec, input int ee);
    chk({name, "_load_a"}, 32'(na - na0), 32'(ea));
    chk({name, "_load_c"}, 32'(nc - nc0), 32'(ec));
    chk({name, "_error"},  32'(ne - ne0), 32'(ee));
  endtask

  task automatic second();
    one_second = 1'b1;
    @(negedge clk);
    one_second = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{4'd1,  16'h0001, 1'b1};
    vecs[1] = '{4'd2,  16'h0012, 1'b1};
    vecs[2] = '{4'd12, 16'h0012, 1'b1};
    vecs[3] = '{4'd3,  16'h0123, 1'b1};
    vecs[4] = '{4'd4,  16'h1234, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_digits", 32'(digits()), 32'h0);
    chk("reset_show", 32'(show_new_time), 32'h0);
    chk("reset_strobes", 32'(na + nc + ne), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1,2,(non-digit),3,4 then time commit
    for (int i = 0; i < 5; i++) begin
      press(vecs[i].code);
      chk($sformatf("vec%0d_digits", i),
          32'(digits()), 32'(vecs[i].exp_dig));
      chk($sformatf("vec%0d_show", i),
          32'(show_new_time), 32'(vecs[i].exp_show));
    end
    buttons(1'b0, 1'b1);
    strobes("commit_time", 0, 1, 0);
    chk("commit_time_show", 32'(show_new_time), 32'h0);
    chk("commit_time_hold", 32'(digits()), 32'h1234);

    // short glitch must not register a digit
    key_code = 4'd7;
    key_pressed = 1'b1;
    repeat (2) @(negedge clk);
    key_pressed = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("glitch_digits", 32'(digits()), 32'h1234);
    chk("glitch_show", 32'(show_new_time), 32'h0);

    // commit with no entry in progress is ignored
    buttons(1'b1, 1'b0);
    strobes("idle_commit", 0, 0, 0);

    // 24:00 is illegal
    press(4'd2); press(4'd4); press(4'd0); press(4'd0);
    chk("e2400_digits", 32'(digits()), 32'h2400);
    buttons(1'b1, 1'b0);
    strobes("e2400", 0, 0, 1);
    chk("e2400_clear", 32'(digits()), 32'h0);
    chk("e2400_show", 32'(show_new_time), 32'h0);

    // 12:60 is illegal
    press(4'd1); press(4'd2); press(4'd6); press(4'd0);
    buttons(1'b0, 1'b1);
    strobes("e1260", 0, 0, 1);

    // 23:59 is the upper legal bound
    press(4'd2); press(4'd3); press(4'd5); press(4'd9);
    buttons(1'b0, 1'b1);
    strobes("t2359", 0, 1, 0);
    chk("t2359_digits", 32'(digits()), 32'h2359);

    // timeout after 10 seconds of inactivity
    press(4'd0); press(4'd7);
    chk("tmo_start", 32'(digits()), 32'h0007);
    na0 = na; nc0 = nc; ne0 = ne;
    repeat (9) second();
    chk("tmo_9_show", 32'(show_new_time), 32'h1);
    chk("tmo_9_digits", 32'(digits()), 32'h0007);
    second();
    chk("tmo_10_show", 32'(show_new_time), 32'h0);
    chk("tmo_10_digits", 32'(digits()), 32'h0);
    strobes("tmo", 0, 0, 0);

    // simultaneous edges ignored, then alarm alone
    press(4'd0); press(4'd9); press(4'd3); press(4'd0);
    buttons(1'b1, 1'b1);
    strobes("both", 0, 0, 0);
    chk("both_show", 32'(show_new_time), 32'h1);
    buttons(1'b1, 1'b0);
    strobes("alarm", 1, 0, 0);
    chk("alarm_digits", 32'(digits()), 32'h0930);
    chk("alarm_show", 32'(show_new_time), 32'h0);

    // reset during debounce discards partial entry
    press(4'd1); press(4'd2);
    chk("rst_pre", 32'(digits()), 32'h0012);
    na0 = na; nc0 = nc; ne0 = ne;
    key_code = 4'd3;
    key_pressed = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_in_debounce", 32'(dut.state_q), 32'(S_DEBOUNCE));
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_digits", 32'(digits()), 32'h0);
    chk("rst_async_show", 32'(show_new_time), 32'h0);
    key_pressed = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    press(4'd5);
    chk("rst_after_digits", 32'(digits()), 32'h0005);
    chk("rst_after_show", 32'(show_new_time), 32'h1);
    strobes("rst", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: clk cycles a key code must be stable before acceptance.
REQ-002 Parameter TIMEOUT_SECS, default 10: one_second pulses without a new digit before entry aborts.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 key_pressed  in  1  raw keypad "key down" level, asynchronous to clk.
REQ-006 key_code  in  4  raw key value; 0-9 digit, 10-15 non-digit.
REQ-007 one_second  in  1  one-cycle pulse per second.
REQ-008 alarm_button  in  1  request to commit buffer as alarm time (level, synchronous).
REQ-009 time_button  in  1  request to commit buffer as current time (level, synchronous).
REQ-010 key_ms_hr, key_ls_hr, key_ms_min, key_ls_min  out  4 each  entered BCD digits.
REQ-011 show_new_time  out  1  high while an entry is in progress.
REQ-012 load_new_a  out  1  one-cycle strobe: digits are a valid new alarm time.
REQ-013 load_new_c  out  1  one-cycle strobe: digits are a valid new current time.
REQ-014 entry_error  out  1  one-cycle strobe: commit refused, digits not a legal time.

Function
REQ-015 key_pressed and key_code SHALL pass a 2-flop synchroniser before use.
REQ-016 FSM states SHALL be IDLE, DEBOUNCE, STORE, WAIT_RELEASE.
REQ-017 IDLE -> DEBOUNCE on synchronised key_pressed high; debounce counter cleared, code sampled.
REQ-018 DEBOUNCE: counter increments while key_pressed high and code equals sample; any change returns to IDLE.
REQ-019 DEBOUNCE -> STORE when counter reaches DEBOUNCE_CYCLES-1 with condition still true.
REQ-020 STORE lasts exactly one cycle, then -> WAIT_RELEASE; digit codes (0-9) shift in, codes 10-15 discarded silently.
REQ-021 Shift SHALL be left: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=new digit.
REQ-022 WAIT_RELEASE -> IDLE only after key_pressed low for DEBOUNCE_CYCLES consecutive cycles; one digit per press.
REQ-023 show_new_time SHALL set the cycle after the first accepted digit and clear on commit, error, or timeout.
REQ-024 Timeout counter (clog2(TIMEOUT_SECS+1) bits, saturating) SHALL clear on each STORE of a digit, increment on one_second while show_new_time high.
REQ-025 Reaching TIMEOUT_SECS SHALL clear all four digits to 0 and show_new_time to 0; no strobe.
REQ-026 Commit SHALL trigger on the rising edge of alarm_button or time_button, only while show_new_time high; otherwise ignored.
REQ-027 Legal time: ms_hr<=2; ls_hr<=3 if ms_hr==2; ms_min<=5 (other digits 0-9 by construction).
REQ-028 Legal commit SHALL pulse load_new_a (alarm) or load_new_c (time) for one cycle, registered, one cycle after the edge; digits held until the next entry.
REQ-029 Illegal commit SHALL pulse entry_error one cycle, clear digits to 0.
REQ-030 Rising edges of both buttons in the same cycle SHALL be ignored entirely (no strobe, no error).
REQ-031 Commit edge coincident with STORE: commit uses pre-shift digits; the digit is discarded.
REQ-032 Timeout coincident with STORE: STORE wins; counter cleared, no clear of digits.
REQ-033 The first digit after commit, error, or timeout SHALL begin from cleared digits (0000).

Reset
REQ-034 reset_n low SHALL immediately force FSM IDLE, all counters 0, all digits 0, show_new_time 0, all strobes 0, synchroniser and button-edge flops 0.
REQ-035 Reset asserted mid-debounce or mid-entry SHALL discard partial entry without any strobe.

Structure
REQ-036 A shared package SHALL hold the FSM state enumeration, KEY_NONE-range boundary (10), and time-limit constants (2, 3, 5).
REQ-037 Debounce counter/comparison SHALL be a sub-module key_debounce; FSM, shift register, timeout, and commit logic stay in keypad_entry.

Verification
REQ-038 Press 1,2,3,4 each held 6 cycles, release 6 cycles -> digits 1,2,3,4; show_new_time 1; then time_button edge -> load_new_c one pulse, show_new_time 0.
REQ-039 key_pressed glitch high 2 cycles with DEBOUNCE_CYCLES=4 -> no digit stored, FSM back to IDLE.
REQ-040 Enter 2,4,0,0 then alarm_button -> entry_error pulse, no load_new_a, digits 0000.
REQ-041 Enter 0,7, then 10 one_second pulses without keys -> digits 0000, show_new_time 0, no strobes.
REQ-042 Enter 0,9,3,0, assert alarm_button and time_button same cycle -> no strobe; then alarm_button alone -> load_new_a.
REQ-043 Assert reset_n low during DEBOUNCE after digits 1,2 -> all outputs 0 asynchronously; after release, key 5 -> digits 0,0,0,5.
